// File: rtl/gcd_pkg.sv
// gcd_pkg: shared state encoding and default sizes for the GCD engine.
package gcd_pkg;

    localparam int GCD_DEFAULT_WIDTH = 7;
    localparam int GCD_DEFAULT_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } gcd_state_t;

endpackage

// File: rtl/gcd_cmp.sv
// gcd_cmp: WIDTH-bit unsigned magnitude comparator used on the working pair.
module gcd_cmp
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             a_gt_b,
    output logic             a_lt_b,
    output logic             a_eq_b
);

    assign a_gt_b = (a > b);
    assign a_lt_b = (a < b);
    assign a_eq_b = (a == b);

endmodule

// File: rtl/gcd_engine.sv
// gcd_engine: iterative subtractive-Euclid GCD with valid/ready input and output.
// One operand pair is processed at a time; a zero/zero pair reports err.
// Build macro GCD_ITER_CNT_EN adds the iter_cnt port and its saturating counter.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_DEFAULT_WIDTH,
    parameter int CNT_W = GCD_DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gcd_out,
`ifdef GCD_ITER_CNT_EN
    output logic             err,
    output logic [CNT_W-1:0] iter_cnt
`else
    output logic             err
`endif
);

    gcd_state_t       r_state;
    logic [WIDTH-1:0] r_ta;
    logic [WIDTH-1:0] r_tb;
    logic [WIDTH-1:0] r_gcd;
    logic             r_err;

    logic             w_taGtTb;
    logic             w_taLtTb;
    logic             w_taEqTb;
    logic             w_taZero;
    logic             w_tbZero;
    logic [WIDTH-1:0] w_taMinusTb;
    logic [WIDTH-1:0] w_tbMinusTa;

    gcd_cmp #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .a      (r_ta),
        .b      (r_tb),
        .a_gt_b (w_taGtTb),
        .a_lt_b (w_taLtTb),
        .a_eq_b (w_taEqTb)
    );

    assign w_taZero    = (r_ta == '0);
    assign w_tbZero    = (r_tb == '0);
    assign w_taMinusTb = r_ta - r_tb;
    assign w_tbMinusTa = r_tb - r_ta;

    // Handshake flags come straight from the state register; in_ready is held low during reset
    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = (r_state == DONE);
    assign gcd_out   = r_gcd;
    assign err       = r_err;

    // Control FSM: latch a pair in IDLE, reduce it in CALC, hold the result in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ta    <= '0;
            r_tb    <= '0;
            r_gcd   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_ta    <= a_in;
                        r_tb    <= b_in;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    if (w_taZero) begin
                        r_gcd   <= r_tb;
                        r_err   <= w_tbZero;
                        r_state <= DONE;
                    end else if (w_tbZero) begin
                        r_gcd   <= r_ta;
                        r_err   <= 1'b0;
                        r_state <= DONE;
                    end else if (w_taEqTb) begin
                        r_gcd   <= r_ta;
                        r_err   <= 1'b0;
                        r_state <= DONE;
                    end else if (w_taGtTb) begin
                        r_ta <= w_taMinusTb;
                    end else if (w_taLtTb) begin
                        r_tb <= w_tbMinusTa;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef GCD_ITER_CNT_EN
    logic [CNT_W-1:0] r_iterCnt;
    logic             w_load;
    logic             w_subStep;

    assign w_load    = (r_state == IDLE) && in_valid;
    assign w_subStep = (r_state == CALC) && !w_taZero && !w_tbZero && !w_taEqTb;
    assign iter_cnt  = r_iterCnt;

    // Count subtraction cycles of the current pair, sticking at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            r_iterCnt <= '0;
        end else if (w_load) begin
            r_iterCnt <= '0;
        end else if (w_subStep && (r_iterCnt != '1)) begin
            r_iterCnt <= r_iterCnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: directed checks of gcd_engine at WIDTH=7 and WIDTH=16.
// Honours GCD_ITER_CNT_EN to connect and check iter_cnt.
// Latency is counted in cycles with the accepting cycle as cycle 1, so a pair
// needing S subtractions shows out_valid in cycle S+2.
module tb_gcd_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       inValid, inReady, outValid, outReady, err7;
    logic [6:0] aIn, bIn, gcd7;

    logic        inValid16, inReady16, outValid16, outReady16, err16;
    logic [15:0] aIn16, bIn16, gcd16;

`ifdef GCD_ITER_CNT_EN
    logic [7:0] cnt7;
    logic [7:0] cnt16;
`endif

    int total = 0;
    int bad   = 0;

    gcd_engine #(.WIDTH(7), .CNT_W(8)) dut7 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .a_in      (aIn),
        .b_in      (bIn),
        .out_valid (outValid),
        .out_ready (outReady),
        .gcd_out   (gcd7),
`ifdef GCD_ITER_CNT_EN
        .err       (err7),
        .iter_cnt  (cnt7)
`else
        .err       (err7)
`endif
    );

    gcd_engine #(.WIDTH(16), .CNT_W(8)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid16),
        .in_ready  (inReady16),
        .a_in      (aIn16),
        .b_in      (bIn16),
        .out_valid (outValid16),
        .out_ready (outReady16),
        .gcd_out   (gcd16),
`ifdef GCD_ITER_CNT_EN
        .err       (err16),
        .iter_cnt  (cnt16)
`else
        .err       (err16)
`endif
    );

    // Reference: modulo Euclid for the value, quotient sum for the subtraction count
    function automatic void gcd_model(input int a, input int b,
                                      output int g, output int e, output int s);
        int x, y, r;
        s = 0;
        e = (a == 0 && b == 0) ? 1 : 0;
        if (a == 0) begin
            g = b;
        end else if (b == 0) begin
            g = a;
        end else begin
            x = a;
            y = b;
            while (y != 0) begin
                s = s + x / y;
                r = x % y;
                x = y;
                y = r;
            end
            g = x;
            s = s - 1;
        end
    endfunction

    // Drive one pair into the 7-bit engine, measure latency and collect the result
    task automatic applyStimulus7(input logic [6:0] a, input logic [6:0] b,
                                  output int lat, output logic [6:0] g, output logic e,
                                  output logic [7:0] c, output bit timedOut);
        int n;
        timedOut = 1'b0;
        c = 8'd0;
        @(negedge clk);
        inValid = 1'b1;
        aIn = a;
        bIn = b;
        n = 0;
        while (!inReady && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        lat = 1;
        while (!outValid && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        timedOut = !outValid;
        g = gcd7;
        e = err7;
`ifdef GCD_ITER_CNT_EN
        c = cnt7;
`endif
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
    endtask

    // Same as above for the 16-bit engine
    task automatic applyStimulus16(input logic [15:0] a, input logic [15:0] b,
                                   output int lat, output logic [15:0] g, output logic e,
                                   output logic [7:0] c, output bit timedOut);
        int n;
        timedOut = 1'b0;
        c = 8'd0;
        @(negedge clk);
        inValid16 = 1'b1;
        aIn16 = a;
        bIn16 = b;
        n = 0;
        while (!inReady16 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        inValid16 = 1'b0;
        lat = 1;
        while (!outValid16 && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        timedOut = !outValid16;
        g = gcd16;
        e = err16;
`ifdef GCD_ITER_CNT_EN
        c = cnt16;
`endif
        outReady16 = 1'b1;
        @(negedge clk);
        outReady16 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        inValid = 1'b0; outReady = 1'b0; aIn = '0; bIn = '0;
        inValid16 = 1'b0; outReady16 = 1'b0; aIn16 = '0; bIn16 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (inReady !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready: got %0b want 0", inReady); end
        total++; if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %0b want 0", outValid); end
        total++; if (gcd7 !== 7'd0) begin bad++; $display("[TB] FAIL reset_gcd: got %0d want 0", gcd7); end
        total++; if (err7 !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %0b want 0", err7); end
        total++; if (inReady16 !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready16: got %0b want 0", inReady16); end
`ifdef GCD_ITER_CNT_EN
        total++; if (cnt7 !== 8'd0) begin bad++; $display("[TB] FAIL reset_iter_cnt: got %0d want 0", cnt7); end
`endif
        rst = 1'b0;
        @(negedge clk);
        total++; if (inReady !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_in_ready: got %0b want 1", inReady); end
        total++; if (inReady16 !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_in_ready16: got %0b want 1", inReady16); end
    endtask

    task automatic test_basic();
        int lat; logic [6:0] g; logic e; logic [7:0] c; bit to;
        applyStimulus7(7'd12, 7'd18, lat, g, e, c, to);
        total++; if (to !== 1'b0) begin bad++; $display("[TB] FAIL basic_timeout: got %0b want 0", to); end
        total++; if (g !== 7'd6) begin bad++; $display("[TB] FAIL basic_gcd: got %0d want 6", g); end
        total++; if (e !== 1'b0) begin bad++; $display("[TB] FAIL basic_err: got %0b want 0", e); end
        total++; if (lat !== 4) begin bad++; $display("[TB] FAIL basic_latency: got %0d want 4", lat); end
`ifdef GCD_ITER_CNT_EN
        total++; if (c !== 8'd2) begin bad++; $display("[TB] FAIL basic_iter_cnt: got %0d want 2", c); end
`endif
    endtask

    task automatic test_equal_worst();
        int lat; logic [6:0] g; logic e; logic [7:0] c; bit to;
        applyStimulus7(7'd35, 7'd35, lat, g, e, c, to);
        total++; if (g !== 7'd35) begin bad++; $display("[TB] FAIL equal_gcd: got %0d want 35", g); end
        total++; if (lat !== 2) begin bad++; $display("[TB] FAIL equal_latency: got %0d want 2", lat); end
`ifdef GCD_ITER_CNT_EN
        total++; if (c !== 8'd0) begin bad++; $display("[TB] FAIL equal_iter_cnt: got %0d want 0", c); end
`endif
        applyStimulus7(7'd127, 7'd1, lat, g, e, c, to);
        total++; if (to !== 1'b0) begin bad++; $display("[TB] FAIL worst_timeout: got %0b want 0", to); end
        total++; if (g !== 7'd1) begin bad++; $display("[TB] FAIL worst_gcd: got %0d want 1", g); end
        total++; if (lat !== 128) begin bad++; $display("[TB] FAIL worst_latency: got %0d want 128", lat); end
`ifdef GCD_ITER_CNT_EN
        total++; if (c !== 8'd126) begin bad++; $display("[TB] FAIL worst_iter_cnt: got %0d want 126", c); end
`endif
    endtask

    task automatic test_zero();
        int lat; logic [6:0] g; logic e; logic [7:0] c; bit to;
        applyStimulus7(7'd0, 7'd35, lat, g, e, c, to);
        total++; if (g !== 7'd35) begin bad++; $display("[TB] FAIL zero_a_gcd: got %0d want 35", g); end
        total++; if (e !== 1'b0) begin bad++; $display("[TB] FAIL zero_a_err: got %0b want 0", e); end
        total++; if (lat !== 2) begin bad++; $display("[TB] FAIL zero_a_latency: got %0d want 2", lat); end
        applyStimulus7(7'd42, 7'd0, lat, g, e, c, to);
        total++; if (g !== 7'd42) begin bad++; $display("[TB] FAIL zero_b_gcd: got %0d want 42", g); end
        total++; if (e !== 1'b0) begin bad++; $display("[TB] FAIL zero_b_err: got %0b want 0", e); end
        applyStimulus7(7'd0, 7'd0, lat, g, e, c, to);
        total++; if (g !== 7'd0) begin bad++; $display("[TB] FAIL zero_both_gcd: got %0d want 0", g); end
        total++; if (e !== 1'b1) begin bad++; $display("[TB] FAIL zero_both_err: got %0b want 1", e); end
    endtask

    task automatic test_back_pressure();
        int n;
        @(negedge clk);
        inValid = 1'b1; aIn = 7'd12; bIn = 7'd18; outReady = 1'b0;
        @(posedge clk);
        @(negedge clk);
        aIn = 7'd5; bIn = 7'd10;
        n = 0;
        while (!outValid && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++; if (outValid !== 1'b1) begin bad++; $display("[TB] FAIL bp_reach_done: got %0b want 1", outValid); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (outValid !== 1'b1) begin bad++; $display("[TB] FAIL bp_out_valid[%0d]: got %0b want 1", i, outValid); end
            total++; if (gcd7 !== 7'd6) begin bad++; $display("[TB] FAIL bp_gcd[%0d]: got %0d want 6", i, gcd7); end
            total++; if (err7 !== 1'b0) begin bad++; $display("[TB] FAIL bp_err[%0d]: got %0b want 0", i, err7); end
            total++; if (inReady !== 1'b0) begin bad++; $display("[TB] FAIL bp_in_ready[%0d]: got %0b want 0", i, inReady); end
        end
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        inValid = 1'b0;
        total++; if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL bp_release_valid: got %0b want 0", outValid); end
        total++; if (inReady !== 1'b1) begin bad++; $display("[TB] FAIL bp_release_ready: got %0b want 1", inReady); end
        @(negedge clk);
        total++; if (inReady !== 1'b1) begin bad++; $display("[TB] FAIL bp_stays_idle: got %0b want 1", inReady); end
    endtask

    task automatic test_reset_mid_calc();
        int seen;
        @(negedge clk);
        inValid = 1'b1; aIn = 7'd127; bIn = 7'd1;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (inReady !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_in_ready_low: got %0b want 0", inReady); end
        @(negedge clk);
        rst = 1'b0;
        total++; if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_out_valid: got %0b want 0", outValid); end
        total++; if (gcd7 !== 7'd0) begin bad++; $display("[TB] FAIL rstmid_gcd: got %0d want 0", gcd7); end
        #1;
        total++; if (inReady !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_in_ready: got %0b want 1", inReady); end
        seen = 0;
        repeat (140) begin
            @(negedge clk);
            if (outValid) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("[TB] FAIL rstmid_stale_result: got %0d want 0", seen); end
    endtask

    task automatic test_width16();
        int lat, mg, me, ms, msat;
        logic [15:0] g; logic e; logic [7:0] c; bit to;
        logic [15:0] ra, rb;
        // 48879 = 17*2875 + 4, so the pair is coprime: gcd 1 after 44 subtractions
        applyStimulus16(16'd48879, 16'd4913, lat, g, e, c, to);
        total++; if (g !== 16'd1) begin bad++; $display("[TB] FAIL w16_beef_gcd: got %0d want 1", g); end
        total++; if (lat !== 46) begin bad++; $display("[TB] FAIL w16_beef_latency: got %0d want 46", lat); end
`ifdef GCD_ITER_CNT_EN
        total++; if (c !== 8'd44) begin bad++; $display("[TB] FAIL w16_beef_iter_cnt: got %0d want 44", c); end
`endif
        // 599 subtractions pushes the 8-bit counter into saturation
        applyStimulus16(16'd600, 16'd1, lat, g, e, c, to);
        total++; if (g !== 16'd1) begin bad++; $display("[TB] FAIL w16_sat_gcd: got %0d want 1", g); end
        total++; if (lat !== 601) begin bad++; $display("[TB] FAIL w16_sat_latency: got %0d want 601", lat); end
`ifdef GCD_ITER_CNT_EN
        total++; if (c !== 8'd255) begin bad++; $display("[TB] FAIL w16_sat_iter_cnt: got %0d want 255", c); end
`endif
        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom_range(0, 600));
            rb = 16'($urandom_range(0, 600));
            gcd_model(int'(ra), int'(rb), mg, me, ms);
            msat = (ms > 255) ? 255 : ms;
            applyStimulus16(ra, rb, lat, g, e, c, to);
            total++; if (int'(g) !== mg) begin bad++; $display("[TB] FAIL w16_rand_gcd(%0d,%0d): got %0d want %0d", ra, rb, g, mg); end
            total++; if (int'(e) !== me) begin bad++; $display("[TB] FAIL w16_rand_err(%0d,%0d): got %0b want %0d", ra, rb, e, me); end
            total++; if (lat !== ms + 2) begin bad++; $display("[TB] FAIL w16_rand_latency(%0d,%0d): got %0d want %0d", ra, rb, lat, ms + 2); end
`ifdef GCD_ITER_CNT_EN
            total++; if (int'(c) !== msat) begin bad++; $display("[TB] FAIL w16_rand_iter_cnt(%0d,%0d): got %0d want %0d", ra, rb, c, msat); end
`endif
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_basic();
        test_equal_worst();
        test_zero();
        test_back_pressure();
        test_reset_mid_calc();
        test_width16();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
